// File: rtl/riscv_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Define RISCV_MULDIV_DIV_EN to build the divide datapath; without it divide ops complete at once flagged illegal.
module riscv_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            illegal
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc, acc_nxt, prod;
    logic [XLEN-1:0]   opb;
    logic              neg, sel_hi;

    logic              accept, last_iter, fast, fast_ill;
    logic              sgn_a, sgn_b, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag, fast_res, final_res;
    logic [XLEN:0]     mul_sum;

    function automatic logic [2*XLEN-1:0] cneg_wide(input logic [2*XLEN-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [XLEN-1:0] cneg(input logic [XLEN-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    assign accept    = (state == IDLE) && start;
    assign last_iter = (state == CALC) && (cnt == LAST);

    // MUL takes unsigned magnitudes: the low half of the product is sign-agnostic.
    always_comb begin
        sgn_a = 1'b0;
        sgn_b = 1'b0;
        if (func3[2]) begin
            sgn_a = ~func3[0];
            sgn_b = ~func3[0];
        end else begin
            sgn_a = (func3[1:0] == 2'b01) || (func3[1:0] == 2'b10);
            sgn_b = (func3[1:0] == 2'b01);
        end
    end

    assign a_neg = sgn_a & A[XLEN-1];
    assign b_neg = sgn_b & B[XLEN-1];
    assign a_mag = cneg(A, a_neg);
    assign b_mag = cneg(B, b_neg);

`ifdef RISCV_MULDIV_DIV_EN
    logic            is_div, is_rem, div_zero, div_ovf, div_ge;
    logic [XLEN:0]   div_sh;
    logic [XLEN-1:0] div_rem;

    assign div_zero = func3[2] && (B == '0);
    assign div_ovf  = func3[2] && !func3[0] && (A == {1'b1, {(XLEN-1){1'b0}}}) && (B == '1);
    assign fast     = div_zero || div_ovf;
    assign fast_ill = 1'b0;

    always_comb begin
        if (div_zero) fast_res = func3[1] ? A : '1;
        else          fast_res = func3[1] ? '0 : A;
    end

    // acc holds {remainder, dividend/quotient}; one quotient bit enters at the bottom per step.
    assign div_sh  = acc[2*XLEN-1:XLEN-1];
    assign div_ge  = div_sh >= {1'b0, opb};
    assign div_rem = div_ge ? (div_sh[XLEN-1:0] - opb) : div_sh[XLEN-1:0];
    assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    assign acc_nxt = is_div ? {div_rem, acc[XLEN-2:0], div_ge} : {mul_sum, acc[XLEN-1:1]};
    assign prod    = cneg_wide(acc_nxt, neg);

    always_comb begin
        if (is_div)      final_res = cneg(is_rem ? acc_nxt[2*XLEN-1:XLEN] : acc_nxt[XLEN-1:0], neg);
        else if (sel_hi) final_res = prod[2*XLEN-1:XLEN];
        else             final_res = prod[XLEN-1:0];
    end
`else
    assign fast     = func3[2];
    assign fast_ill = 1'b1;
    assign fast_res = '0;

    assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    assign acc_nxt   = {mul_sum, acc[XLEN-1:1]};
    assign prod      = cneg_wide(acc_nxt, neg);
    assign final_res = sel_hi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = fast ? DONE : CALC;
            CALC:    if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            result  <= '0;
            illegal <= 1'b0;
        end else begin
            if (accept)              cnt <= '0;
            else if (state == CALC)  cnt <= cnt + CW'(1);
            if (accept && fast) begin
                result  <= fast_res;
                illegal <= fast_ill;
            end else if (last_iter) begin
                result  <= final_res;
                illegal <= 1'b0;
            end
        end
    end

    // Operand/accumulator state is only meaningful after an accept, so it carries no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            acc    <= {{XLEN{1'b0}}, a_mag};
            opb    <= b_mag;
            neg    <= (func3[2] && func3[1]) ? a_neg : (a_neg ^ b_neg);
            sel_hi <= (func3[1:0] != 2'b00);
`ifdef RISCV_MULDIV_DIV_EN
            is_div <= func3[2];
            is_rem <= func3[1];
`endif
        end else if (state == CALC) begin
            acc <= acc_nxt;
        end
    end
endmodule

// File: tb/tb_riscv_muldiv.sv
// Randomized self-checking bench for riscv_muldiv against an arithmetic reference model.
`timescale 1ns/1ps
module tb_riscv_muldiv;
    localparam int XLEN = 32;
`ifdef RISCV_MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  func3;
    logic [31:0] A, B;
    logic        busy, done, illegal;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    riscv_muldiv #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .start(start), .func3(func3), .A(A), .B(B),
        .busy(busy), .done(done), .result(result), .illegal(illegal)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        int          si, sj;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        si = a;
        sj = b;
        if (f[2] && !DIV_EN) return 32'h0;
        case (f)
            3'b000: begin p = ua * ub; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                return si / sj;
            end
            3'b101: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return si % sj;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (!f[2]) return XLEN + 1;
        if (!DIV_EN) return 1;
        if (b == 0) return 1;
        if (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
        return XLEN + 1;
    endfunction

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    // poke: cycle index during the operation at which a stray start is pulsed (0 = never).
    // poke_done: also hold start high while done is asserted; it must not be accepted.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int poke, input bit poke_done);
        int n;
        bit seen, busy_ok;
        @(negedge clk);
        func3 = f; A = a; B = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        func3 = 3'($urandom); A = $urandom; B = $urandom;
        n = 0; seen = 1'b0; busy_ok = 1'b1;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            start = 1'b0;
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                seen = 1'b1;
                if (poke_done) begin
                    start = 1'b1; func3 = 3'($urandom); A = $urandom; B = $urandom;
                end
            end else if (n == poke) begin
                start = 1'b1; func3 = 3'($urandom); A = $urandom; B = $urandom;
            end
        end
        check({tag, "_done"}, 64'(seen), 64'd1);
        check({tag, "_lat"}, 64'(n), 64'(ref_latency(f, a, b)));
        check({tag, "_res"}, {32'b0, result}, {32'b0, ref_result(f, a, b)});
        check({tag, "_ill"}, {63'b0, illegal}, {63'b0, (f[2] && !DIV_EN)});
        check({tag, "_busy"}, 64'(busy_ok), 64'd1);
        @(negedge clk);
        check({tag, "_idle"}, {63'b0, busy}, 64'd0);
        start = 1'b0;
    endtask

    initial begin
        int dones;
        rst = 1'b1; start = 1'b0; func3 = 3'b0; A = 32'b0; B = 32'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", {63'b0, busy}, 64'd0);
        check("reset_done", {63'b0, done}, 64'd0);
        check("reset_result", {32'b0, result}, 64'd0);
        check("reset_illegal", {63'b0, illegal}, 64'd0);
        rst = 1'b0;

        run_op("mul_6x4", 3'b000, 32'd6, 32'd4, 0, 1'b0);
        check("mul_6x4_lit", {32'b0, result}, 64'h18);
        run_op("mulhu_ff", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0);
        check("mulhu_ff_lit", {32'b0, result}, 64'hFFFFFFFE);
        run_op("mulh_ff", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0);
        run_op("mulhsu_m1x2", 3'b010, 32'hFFFFFFFF, 32'd2, 0, 1'b0);
        check("mulhsu_lit", {32'b0, result}, 64'hFFFFFFFF);
        run_op("div_m7_2", 3'b100, 32'hFFFFFFF9, 32'd2, 0, 1'b0);
        run_op("rem_m7_2", 3'b110, 32'hFFFFFFF9, 32'd2, 0, 1'b0);
        run_op("divu_6_4", 3'b101, 32'd6, 32'd4, 0, 1'b0);
        run_op("remu_6_4", 3'b111, 32'd6, 32'd4, 0, 1'b0);
        run_op("divu_by0", 3'b101, 32'd6, 32'd0, 0, 1'b0);
        run_op("rem_by0", 3'b110, 32'd6, 32'd0, 0, 1'b0);
        run_op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 0, 1'b0);
        run_op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 0, 1'b0);
        run_op("divu_big", 3'b101, 32'h80000000, 32'hFFFFFFFF, 0, 1'b0);

        run_op("mul_poke_calc", 3'b000, 32'd6, 32'd4, 5, 1'b0);
        check("mul_poke_lit", {32'b0, result}, 64'h18);
        run_op("mul_poke_done", 3'b000, 32'd3, 32'd5, 0, 1'b1);

        // Reset in the middle of an operation: outputs drop at once, no done follows.
        @(negedge clk);
        func3 = 3'b000; A = 32'd7; B = 32'd9; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", {63'b0, busy}, 64'd0);
        check("midrst_done", {63'b0, done}, 64'd0);
        check("midrst_result", {32'b0, result}, 64'd0);
        check("midrst_illegal", {63'b0, illegal}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("midrst_no_done", 64'(dones), 64'd0);
        run_op("after_rst", 3'b000, 32'd6, 32'd4, 0, 1'b0);

        for (int i = 0; i < 150; i++) begin
            run_op("rand", 3'($urandom), rnd_opnd(), rnd_opnd(),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : 0,
                   1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
